// File: rtl/scan_pkg.sv
// Shared definitions for the scan chain tile.
//   phase_t     : scan clock phase FSM states (ST_LOW, ST_HIGH)
//   SYNC_DEPTH  : number of synchronizer flops ahead of the edge stage
//   NUM_IOS_DEF : default number of bits per tile
package scan_pkg;

    localparam int SYNC_DEPTH  = 2;
    localparam int NUM_IOS_DEF = 8;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } phase_t;

endpackage

// File: rtl/scan_sync_edge.sv
// Synchronizer + edge detector for one asynchronous scan input.
//   clk, reset_n : tile clock, async active-low reset
//   din          : raw asynchronous input
//   level        : synchronized (optionally filtered) level
//   rise, fall   : single-cycle edge strobes derived from level
// Build option SCAN_TILE_GLITCH_FILTER_EN inserts a 3-sample majority
// filter after the synchronizer. It adds exactly one cycle on a clean
// edge, so every input gets it and clock/data/select/latch stay aligned;
// on clock and latch it also swallows single-cycle glitches.
module scan_sync_edge
    import scan_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_DEPTH-1:0] sync;   // sync[0] = s1, sync[SYNC_DEPTH-1] = s2
    logic                  s3;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) sync <= '0;
        else          sync <= {sync[SYNC_DEPTH-2:0], din};
    end

`ifdef SCAN_TILE_GLITCH_FILTER_EN
    logic [1:0] hist;
    logic       s2;

    assign s2 = sync[SYNC_DEPTH-1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) hist <= '0;
        else          hist <= {hist[0], s2};
    end

    assign level = (s2 & hist[0]) | (s2 & hist[1]) | (hist[0] & hist[1]);
`else
    assign level = sync[SYNC_DEPTH-1];
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) s3 <= 1'b0;
        else          s3 <= level;
    end

    assign rise = level & ~s3;
    assign fall = ~level & s3;

endmodule

// File: rtl/scan_chain_tile.sv
// Scan chain tile: per-design responder in a serial scan chain.
// Oversamples the scan clock/data/select/latch with the local clk, shifts
// NUM_IOS bits per scan clock (MSB leaves first), parallel-captures
// module_data_out when select is high, latches the shift register onto
// module_data_in on a latch-enable rise and regenerates all scan signals
// for the next tile.
//   clk, reset_n          : tile clock (>= 3x scan clock), async active-low reset
//   scan_*_in             : scan signals from previous tile / controller
//   scan_*_out            : regenerated scan signals toward the next tile
//   module_data_in        : latched inputs to the design
//   module_data_out       : design outputs, captured when select is high
//   bit_cnt               : shifting scan clock rises mod NUM_IOS (debug)
// Build option SCAN_TILE_GLITCH_FILTER_EN: majority filter on the scan
// inputs, adds one clk of latency everywhere.
module scan_chain_tile
    import scan_pkg::*;
#(
    parameter int NUM_IOS = NUM_IOS_DEF
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       scan_clk_in,
    input  logic                       scan_data_in,
    input  logic                       scan_select_in,
    input  logic                       scan_latch_en_in,
    output logic                       scan_clk_out,
    output logic                       scan_data_out,
    output logic                       scan_select_out,
    output logic                       scan_latch_en_out,
    output logic [NUM_IOS-1:0]         module_data_in,
    input  logic [NUM_IOS-1:0]         module_data_out,
    output logic [$clog2(NUM_IOS)-1:0] bit_cnt
);

    localparam int CW = $clog2(NUM_IOS);

    // index: 0 = clock, 1 = data, 2 = select, 3 = latch enable
    logic [3:0] raw, lvl, rse, fll;
    logic       unused_edges;

    assign raw = {scan_latch_en_in, scan_select_in, scan_data_in, scan_clk_in};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        scan_sync_edge u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .din     (raw[i]),
            .level   (lvl[i]),
            .rise    (rse[i]),
            .fall    (fll[i])
        );
    end

    // Only clock edges and the latch rise drive decisions.
    assign unused_edges = &{1'b0, rse[2:1], fll[3:1]};

    logic clk_s2, data_s2, select_s2, latch_s2, clk_rise, clk_fall, latch_rise;

    assign clk_s2     = lvl[0];
    assign data_s2    = lvl[1];
    assign select_s2  = lvl[2];
    assign latch_s2   = lvl[3];
    assign clk_rise   = rse[0];
    assign clk_fall   = fll[0];
    assign latch_rise = rse[3];

    // Phase FSM: edges are only acted on from the matching phase.
    phase_t state, state_nxt;
    logic   do_rise, do_fall;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_LOW;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_rise   = 1'b0;
        do_fall   = 1'b0;
        case (state)
            ST_LOW: if (clk_rise) begin
                do_rise   = 1'b1;
                state_nxt = ST_HIGH;
            end
            ST_HIGH: if (clk_fall) begin
                do_fall   = 1'b1;
                state_nxt = ST_LOW;
            end
            default: state_nxt = ST_LOW;
        endcase
    end

    logic [NUM_IOS-1:0] shift;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift             <= '0;
            bit_cnt           <= '0;
            module_data_in    <= '0;
            scan_data_out     <= 1'b0;
            scan_clk_out      <= 1'b0;
            scan_select_out   <= 1'b0;
            scan_latch_en_out <= 1'b0;
        end else begin
            if (do_rise) begin
                if (select_s2) begin
                    // capture clock: bit counter is not advanced
                    shift <= module_data_out;
                end else begin
                    shift   <= {shift[NUM_IOS-2:0], data_s2};
                    bit_cnt <= (bit_cnt == CW'(NUM_IOS - 1)) ? '0 : bit_cnt + 1'b1;
                end
            end
            // Outgoing data moves only on the falling phase, so the next
            // tile sees the pre-rise MSB for the whole high phase.
            if (do_fall) scan_data_out <= shift[NUM_IOS-1];
            // Same-cycle shift takes the pre-shift value (non-blocking read).
            if (latch_rise) module_data_in <= shift;
            scan_clk_out      <= clk_s2;
            scan_select_out   <= select_s2;
            scan_latch_en_out <= latch_s2;
        end
    end

endmodule

// File: tb/tb_scan_chain_tile.sv
// Directed bench for scan_chain_tile: two tiles chained (u0 driven by the
// bench, u1 fed from u0's regenerated outputs).
module tb_scan_chain_tile;

    localparam int N = 8;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic         sclk = 1'b0, sdat = 1'b0, ssel = 1'b0, slat = 1'b0;
    logic [N-1:0] mdo0 = '0, mdo1 = '0;

    logic         c0, d0, s0, l0, c1, d1, s1, l1;
    logic [N-1:0] mdi0, mdi1;
    logic [2:0]   bc0, bc1;

    scan_chain_tile #(.NUM_IOS(N)) u0 (
        .clk               (clk),
        .reset_n           (reset_n),
        .scan_clk_in       (sclk),
        .scan_data_in      (sdat),
        .scan_select_in    (ssel),
        .scan_latch_en_in  (slat),
        .scan_clk_out      (c0),
        .scan_data_out     (d0),
        .scan_select_out   (s0),
        .scan_latch_en_out (l0),
        .module_data_in    (mdi0),
        .module_data_out   (mdo0),
        .bit_cnt           (bc0)
    );

    scan_chain_tile #(.NUM_IOS(N)) u1 (
        .clk               (clk),
        .reset_n           (reset_n),
        .scan_clk_in       (c0),
        .scan_data_in      (d0),
        .scan_select_in    (s0),
        .scan_latch_en_in  (l0),
        .scan_clk_out      (c1),
        .scan_data_out     (d1),
        .scan_select_out   (s1),
        .scan_latch_en_out (l1),
        .module_data_in    (mdi1),
        .module_data_out   (mdo1),
        .bit_cnt           (bc1)
    );

    int n_vec = 0;
    int n_err = 0;
    int bc_exp = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // u0 outgoing data may change only while u0's outgoing clock is low.
    int   dout_viol = 0;
    logic d0_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n && (d0 !== d0_prev) && (c0 === 1'b1)) dout_viol <= dout_viol + 1;
        d0_prev <= d0;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One scan clock, 4 clk per phase; dout is u0's data_out sampled late
    // in the high phase.
    task automatic scan_bit(input logic b, output logic dout);
        sdat = b;
        tick(4);
        sclk = 1'b1;
        tick(3);
        dout = d0;
        tick(1);
        sclk = 1'b0;
        if (!ssel) bc_exp = (bc_exp + 1) % N;
    endtask

    task automatic scan_byte(input logic [N-1:0] v, output logic [N-1:0] emitted);
        logic d;
        for (int i = N - 1; i >= 0; i--) begin
            scan_bit(v[i], d);
            emitted[i] = d;
        end
        tick(4);
    endtask

    task automatic latch_pulse();
        slat = 1'b1;
        tick(6);
        slat = 1'b0;
        tick(6);
    endtask

    initial begin
        logic [N-1:0] em;
        logic         d;

        // reset state
        tick(3);
        chk("rst_mdi", mdi0, 8'h00);
        chk("rst_bitcnt", bc0, 0);
        chk("rst_clk_out", c0, 0);
        chk("rst_data_out", d0, 0);
        chk("rst_sel_out", s0, 0);
        chk("rst_latch_out", l0, 0);
        reset_n = 1'b1;
        tick(4);

        // shift A5: prior contents (zero) come out, counter wraps to 0
        scan_byte(8'hA5, em);
        chk("a5_emitted", em, 8'h00);
        chk("a5_bitcnt", bc0, 0);
        latch_pulse();
        chk("a5_latched", mdi0, 8'hA5);

        // shift 3C, latch with latency check, then hold through shifting
        scan_byte(8'h3C, em);
        chk("3c_emitted", em, 8'hA5);
        slat = 1'b1;
        tick(2);
        chk("3c_latch_early", mdi0, 8'hA5);
        tick(2);
        chk("3c_latch_4clk", mdi0, 8'h3C);
        tick(2);
        slat = 1'b0;
        tick(6);
        for (int i = 0; i < 4; i++) scan_bit(1'b1, d);
        tick(4);
        chk("3c_hold", mdi0, 8'h3C);
        chk("3c_bitcnt", bc0, bc_exp);

        // parallel capture of 96 then unload
        mdo0 = 8'h96;
        ssel = 1'b1;
        scan_bit(1'b0, d);
        ssel = 1'b0;
        chk("cap_bitcnt", bc0, bc_exp);
        scan_byte(8'h00, em);
        chk("cap_unload", em, 8'h96);
        chk("cap_bitcnt_after", bc0, bc_exp);
        mdo0 = 8'h00;

        // two chained tiles: 12 then 34
        scan_byte(8'h12, em);
        scan_byte(8'h34, em);
        chk("chain_up_emitted", em, 8'h12);
        latch_pulse();
        tick(6);
        chk("chain_up", mdi0, 8'h34);
        chk("chain_down", mdi1, 8'h12);

        // latch rise coincident with clock rise
        scan_byte(8'h0F, em);
        sdat = 1'b1;
        tick(4);
        sclk = 1'b1;
        slat = 1'b1;
        tick(4);
        sclk = 1'b0;
        bc_exp = (bc_exp + 1) % N;
        tick(4);
        slat = 1'b0;
        tick(6);
        chk("coinc_mdi", mdi0, 8'h0F);
        latch_pulse();
        chk("coinc_shift", mdi0, 8'h1F);
        chk("coinc_bitcnt", bc0, bc_exp);

        // reset mid-frame after 55 is latched
        scan_byte(8'h55, em);
        latch_pulse();
        chk("pre_rst_mdi", mdi0, 8'h55);
        for (int i = 0; i < 3; i++) scan_bit(1'b1, d);
        sdat = 1'b0;
        tick(4);
        sclk = 1'b1;
        tick(4);
        chk("pre_rst_clk_out", c0, 1);
        chk("pre_rst_data_out", d0, 1);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        sclk = 1'b0;
        #1;
        chk("arst_mdi", mdi0, 8'h00);
        chk("arst_mdi_down", mdi1, 8'h00);
        chk("arst_bitcnt", bc0, 0);
        chk("arst_clk_out", c0, 0);
        chk("arst_data_out", d0, 0);
        #20;
        reset_n = 1'b1;
        bc_exp = 0;
        tick(4);
        scan_byte(8'hFF, em);
        latch_pulse();
        chk("post_rst_ff", mdi0, 8'hFF);
        chk("post_rst_bitcnt", bc0, 0);

        chk("dout_low_only", dout_viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/scan_chain_tile.md
# scan_chain_tile

Per-design responder at the far end of the scan chain driven by `scan_controller`. It sits in series with the other tiles, one per tiny design. It runs on its own system clock and oversamples the incoming scan clock, data, select and latch-enable. It shifts NUM_IOS bits per scan clock, latches them to the design on latch-enable, and parallel-captures the design outputs when select is high. It regenerates all four scan signals toward the next tile.

## Interface
- NUM_IOS, 8: bits per tile (design input and output width)
- clk  in  1  tile system clock; must be at least 3x faster than the scan clock (each scan clock phase at least 3 clk cycles)
- reset_n  in  1  asynchronous, active-low reset
- scan_clk_in  in  1  scan clock from the previous tile or the controller
- scan_data_in  in  1  serial data; stable around the rising scan_clk_in edge
- scan_select_in  in  1  1 = parallel capture of design outputs on the next scan clock rise
- scan_latch_en_in  in  1  rising edge transfers the shift register to module_data_in
- scan_clk_out, scan_data_out, scan_select_out, scan_latch_en_out  out  1 each  regenerated signals toward the next tile
- module_data_in  out  NUM_IOS  inputs to the design (latched)
- module_data_out  in  NUM_IOS  outputs from the design
- bit_cnt  out  $clog2(NUM_IOS)  scan clock rises seen mod NUM_IOS (debug)

## Operation
- Synchronizers: 2-flop synchronizer (s1, s2) on all four scan inputs, plus a third stage s3 for edge detection.
  - rise = s2 & ~s3
  - fall = ~s2 & s3
  - All decisions use s2-stage values, so data, select and latch are time-aligned with the clock.
- Phase FSM: ST_LOW and ST_HIGH, with reset state ST_LOW.
  - ST_LOW -> ST_HIGH on rise.
  - ST_HIGH -> ST_LOW on fall.
  - A rise while in ST_HIGH, or a fall while in ST_LOW, is impossible after synchronization and must not occur.
- On rise, with select_s2 = 0: shift <= {shift[NUM_IOS-2:0], data_s2}.
- On rise, with select_s2 = 1: shift <= module_data_out, and bit_cnt is not advanced.
- On rise with select_s2 = 0: bit_cnt <= (bit_cnt == NUM_IOS-1) ? 0 : bit_cnt+1.
- On fall: scan_data_out <= shift[NUM_IOS-1].
  - Outgoing data therefore changes only while the outgoing clock is low.
  - It holds the pre-rise MSB throughout the high phase, giving true flop-chain semantics.
- Latch: a rising edge of latch_s2 (latch_s2 & ~latch_s3) loads module_data_in <= shift.
- Simultaneous latch rise and clock rise: module_data_in takes the pre-shift value of shift.
- Forwarding, all registered from the s2 stage:
  - scan_clk_out <= clk_s2
  - scan_select_out <= select_s2
  - scan_latch_en_out <= latch_s2
- Reset values: all outputs 0, shift 0, bit_cnt 0, all synchronizer stages 0, FSM in ST_LOW.
- Reset mid-frame: all state is lost, and module_data_in returns to 0 immediately (asynchronous).
- Exit from reset with scan_clk_in already high:
  - s2 rises 2 cycles later and counts as a rise.
  - The controller must hold scan_clk_in low across reset release.

## Timing
- Input scan edge to detected rise/fall: 2-3 clk cycles, depending on the synchronizer sample point.
- Input edge to scan_clk_out edge: equal to detection latency +1 cycle, identical for select and latch outputs.
- scan_data_out updates on the same clk edge as the falling scan_clk_out.
- Setup margin at the next tile is at least one scan high phase.
- Rise to shift register update: registered on the detection cycle, visible the next cycle.
- Latch rise to module_data_in valid: detection cycle +1.
- Minimum scan clock phase: 3 clk cycles.
  - Shorter phases can merge edges in the synchronizer.
  - This behaviour is undefined, and the bench must not rely on it.

## Configuration
- SCAN_TILE_GLITCH_FILTER_EN:
  - Defined: a 3-sample majority filter is inserted after s2 on scan_clk_in and scan_latch_en_in.
    - Data and select get a matching one-cycle delay, preserving alignment.
    - All latencies above increase by 1 cycle.
    - Single-cycle glitches on clock and latch are suppressed.
  - Undefined: no filter; latencies as stated.

## Structure
- Shared package scan_pkg:
  - phase FSM state constants ST_LOW and ST_HIGH
  - SYNC_DEPTH = 2
  - the default NUM_IOS
- One sub-module, scan_sync_edge:
  - 2-flop synchronizer, optional majority filter and s3 edge stage
  - outputs level, rise and fall
  - instantiated per scan input, with edge outputs unused on data and select

## Test plan
- Shift 8 bits 0xA5, MSB first, with scan_clk_in phases of 4 clk -> shift = 0xA5, bit_cnt = 0.
  - scan_data_out emits the prior contents (0x00) bit-by-bit, each bit changing only while scan_clk_out is low.
- Shift 0x3C, then pulse scan_latch_en_in high for 6 clk -> module_data_in = 0x3C, 3-4 clk after the latch edge. It holds through further shifting.
- module_data_out = 0x96, select high, one scan clock, select low, 8 scan clocks -> scan_data_out sequence 1,0,0,1,0,1,1,0. bit_cnt is unaffected by the capture clock.
- Two tiles chained, 16 clocks shifting 0x12 then 0x34 -> downstream tile holds 0x12, upstream tile holds 0x34.
- Latch rise coincident with clock rise while shift = 0x0F and incoming bit 1 -> module_data_in = 0x0F, shift = 0x1F.
- reset_n asserted mid-frame after 0x55 is latched -> all outputs 0 asynchronously. After release, a full frame of 0xFF latches correctly.
